// File: rtl/adder_result_buffer.sv
// -----------------------------------------------------------------------------
// adder_result_buffer
//
// Captures every valid sum produced by the IO-registered pipelined adder and
// hands it to a consumer through a first-word-fall-through queue. The adder
// cannot be stalled, so the block also keeps a credit count: an upstream launch
// is only accepted while storage plus in-flight results still fit in DEPTH
// entries. Each accepted launch reserves a slot, and each returning result
// consumes that reservation.
//
// Handshake: m_valid/m_ready follow strict valid/ready semantics. A transfer
// happens on a rising edge where both are high. While m_valid is high and
// m_ready is low, m_data stays stable. m_valid never depends on m_ready.
// The upstream side has no ready signal. issue is honoured only while
// can_issue = 1, and v_in is always sampled.
//
// Ports:
//   clk           single clock; all state changes on its rising edge
//   rst           asynchronous, active-high reset
//   issue         upstream launches one adder operation this cycle
//   can_issue     a slot is free for another launch (registered state only)
//   v_in, sum_in  adder result valid / value
//   m_valid       head entry available
//   m_data        head entry value
//   m_ready       consumer accepts the head entry
//   count         entries currently stored
//   outstanding   accepted launches whose result has not yet returned
//   err_overflow  sticky: v_in arrived with storage full and no pop
//   err_credit    sticky: issue asserted while can_issue = 0
//   err_underflow sticky: v_in arrived with nothing outstanding
// -----------------------------------------------------------------------------
module adder_result_buffer #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             can_issue,
    input  logic             v_in,
    input  logic [WIDTH-1:0] sum_in,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    outstanding,
    output logic             err_overflow,
    output logic             err_credit,
    output logic             err_underflow
);

    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    outstanding_q;

    logic             full;
    logic             push;
    logic             pop;
    logic             issue_acc;
    logic             ret;
    logic [CW:0]      credit_sum;

    // Equal low bits with different wrap bits means the writer is a full lap
    // ahead of the reader.
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[CW-1] != rd_ptr[CW-1]);

    assign m_valid = (count_q != '0);
    assign m_data  = mem[rd_ptr[AW-1:0]];

    assign pop  = m_valid & m_ready;
    // A full queue can still accept a result in the same cycle it drains one.
    assign push = v_in & (~full | pop);

    // Credits come only from registered state. This keeps the path from issue,
    // v_in and m_ready to can_issue free of combinational loops.
    assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
    assign can_issue  = (credit_sum < (CW+1)'(DEPTH));

    assign issue_acc = issue & can_issue;
    // A result with nothing outstanding is a protocol error. The count is held
    // at zero instead of being allowed to wrap.
    assign ret       = v_in & (outstanding_q != '0);

    assign count       = count_q;
    assign outstanding = outstanding_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= sum_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q       <= count_q + {{(CW-1){1'b0}}, push}
                                     - {{(CW-1){1'b0}}, pop};
            outstanding_q <= outstanding_q + {{(CW-1){1'b0}}, issue_acc}
                                           - {{(CW-1){1'b0}}, ret};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_credit    <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (v_in && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (issue && !can_issue) begin
                err_credit <= 1'b1;
            end
            if (v_in && (outstanding_q == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_adder_result_buffer
//
// Directed bench for adder_result_buffer. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge. Each scenario task drives
// its own stimulus and holds hand-derived expectations. Expected result data
// is kept in exp_q.
// -----------------------------------------------------------------------------
module tb_adder_result_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue = 1'b0;
    logic             can_issue;
    logic             v_in = 1'b0;
    logic [WIDTH-1:0] sum_in = '0;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready = 1'b0;
    logic [CW-1:0]    count;
    logic [CW-1:0]    outstanding;
    logic             err_overflow;
    logic             err_credit;
    logic             err_underflow;

    always #5 clk = ~clk;

    adder_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue         (issue),
        .can_issue     (can_issue),
        .v_in          (v_in),
        .sum_in        (sum_in),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .count         (count),
        .outstanding   (outstanding),
        .err_overflow  (err_overflow),
        .err_credit    (err_credit),
        .err_underflow (err_underflow)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        issue   = 1'b0;
        v_in    = 1'b0;
        m_ready = 1'b0;
        sum_in  = '0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        total++; if (m_data !== 16'h0000) begin bad++; $display("FAIL reset_m_data got=%h want=0000", m_data); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL reset_can_issue got=%0b want=1", can_issue); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err_overflow got=%0b want=0", err_overflow); end
        total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL reset_err_credit got=%0b want=0", err_credit); end
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err_underflow got=%0b want=0", err_underflow); end
    endtask

    // Three launches on consecutive cycles. The results come back 6 cycles
    // later and a ready consumer drains them.
    task automatic test_basic_flow();
        int               exp_out [10] = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0};
        logic [WIDTH-1:0] sums [3]     = '{16'h0003, 16'h0010, 16'hFFFF};
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue  = (i < 3);
            v_in   = (i >= 6) && (i <= 8);
            sum_in = v_in ? sums[i-6] : '0;
            if (v_in) exp_q.push_back(sum_in);
            step();
            total++;
            if (outstanding !== CW'(exp_out[i])) begin
                bad++; $display("FAIL basic_outstanding[%0d] got=%0d want=%0d", i, outstanding, exp_out[i]);
            end
            if (exp_q.size() != 0) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
                    bad++; $display("FAIL basic_head[%0d] got v=%0b d=%h want v=1 d=%h", i, m_valid, m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end else begin
                total++;
                if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_idle[%0d] got m_valid=%0b want=0", i, m_valid); end
            end
        end
        issue = 1'b0; v_in = 1'b0; m_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_count_end got=%0d want=0", count); end
    endtask

    // Consumer stalled: credits run out after DEPTH launches, and a pop frees one.
    task automatic test_credit();
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            issue = 1'b1;
            step();
            total++;
            if (can_issue !== ((k + 1) < DEPTH)) begin
                bad++; $display("FAIL credit_can_issue[%0d] got=%0b want=%0b", k, can_issue, ((k + 1) < DEPTH));
            end
            total++;
            if (err_credit !== (k == 8)) begin
                bad++; $display("FAIL credit_err_credit[%0d] got=%0b want=%0b", k, err_credit, (k == 8));
            end
        end
        issue = 1'b0;
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL credit_outstanding_cap got=%0d want=8", outstanding); end
        for (int j = 0; j < 8; j++) begin
            v_in   = 1'b1;
            sum_in = 16'h0100 + 16'(j);
            exp_q.push_back(sum_in);
            step();
        end
        v_in = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL credit_count_full got=%0d want=8", count); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL credit_outstanding_ret got=%0d want=0", outstanding); end
        total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL credit_full_can_issue got=%0b want=0", can_issue); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL credit_err_overflow got=%0b want=0", err_overflow); end
        total++; if (m_data !== exp_q[0]) begin bad++; $display("FAIL credit_head_hold got=%h want=%h", m_data, exp_q[0]); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        void'(exp_q.pop_front());
        total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL credit_after_pop got=%0b want=1", can_issue); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL credit_count_after_pop got=%0d want=7", count); end
        total++; if (m_data !== exp_q[0]) begin bad++; $display("FAIL credit_next_head got=%h want=%h", m_data, exp_q[0]); end
    endtask

    // Push and pop together while full, then drain. Both pointers wrap.
    task automatic test_full_passthrough();
        issue = 1'b1;
        step();
        issue  = 1'b0;
        v_in   = 1'b1;
        sum_in = 16'h0200;
        exp_q.push_back(sum_in);
        step();
        v_in = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_setup_count got=%0d want=8", count); end
        v_in    = 1'b1;
        m_ready = 1'b1;
        sum_in  = 16'h1234;
        void'(exp_q.pop_front());
        exp_q.push_back(sum_in);
        step();
        v_in = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_pp_count got=%0d want=8", count); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL full_pp_outstanding got=%0d want=0", outstanding); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL full_pp_err_overflow got=%0b want=0", err_overflow); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
                bad++; $display("FAIL full_drain[%0d] got v=%0b d=%h want v=1 d=%h", i, m_valid, m_data, exp_q[0]);
            end
            m_ready = 1'b1;
            step();
            void'(exp_q.pop_front());
        end
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL full_drain_end got v=%0b c=%0d want v=0 c=0", m_valid, count); end
    endtask

    // A result with no launch outstanding while storage is full.
    task automatic test_underflow_overflow();
        apply_reset();
        for (int k = 0; k < 8; k++) begin issue = 1'b1; step(); end
        issue = 1'b0;
        for (int j = 0; j < 8; j++) begin
            v_in   = 1'b1;
            sum_in = 16'h0A00 + 16'(j);
            exp_q.push_back(sum_in);
            step();
        end
        v_in = 1'b0;
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uo_pre_underflow got=%0b want=0", err_underflow); end
        v_in    = 1'b1;
        m_ready = 1'b0;
        sum_in  = 16'hDEAD;
        step();
        v_in = 1'b0;
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uo_err_underflow got=%0b want=1", err_underflow); end
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL uo_err_overflow got=%0b want=1", err_overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL uo_count got=%0d want=8", count); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL uo_outstanding got=%0d want=0", outstanding); end
        total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL uo_err_credit got=%0b want=0", err_credit); end
        total++; if (m_data !== exp_q[0]) begin bad++; $display("FAIL uo_head got=%h want=%h", m_data, exp_q[0]); end
    endtask

    // Asynchronous reset with count = 5 and outstanding = 2. Error flags are
    // still set from the previous scenario.
    task automatic test_reset_midop();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); void'(exp_q.pop_front()); end
        m_ready = 1'b0;
        issue   = 1'b1;
        step();
        step();
        issue = 1'b0;
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_count got=%0d want=5", count); end
        total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL mid_outstanding got=%0d want=2", outstanding); end
        total++; if (m_data !== exp_q[0]) begin bad++; $display("FAIL mid_head got=%h want=%h", m_data, exp_q[0]); end
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL mid_sticky_underflow got=%0b want=1", err_underflow); end
        rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL arst_m_valid got=%0b want=0", m_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", count); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL arst_outstanding got=%0d want=0", outstanding); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL arst_err_overflow got=%0b want=0", err_overflow); end
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL arst_err_underflow got=%0b want=0", err_underflow); end
        total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL arst_err_credit got=%0b want=0", err_credit); end
        total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL arst_can_issue got=%0b want=1", can_issue); end
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_basic_flow();
        test_credit();
        test_full_passthrough();
        test_underflow_overflow();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
